gshare_ctrl: RTL and testbench

Front-end controller that drives both ports of the 2-bit-counter pattern history table (PHT) for a gshare predictor. It forms the PHT read index from the fetch PC and a speculative global history register (GHR). It tracks in-flight conditional branches in a small FIFO. At resolution it issues the PHT update and repairs the history on mispredict or flush. It sits between fetch/execute and the PHT.

---
 rtl/bp_pkg.sv | 16 +
 rtl/bp_inflight_fifo.sv | 54 +++++
 rtl/gshare_ctrl.sv | 123 ++++++++++++
 tb/tb_gshare_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types and default geometry, used by the gshare
// front-end controller and by the pattern history table.
package bp_pkg;

    localparam int BP_INDEX_WIDTH = 12;
    localparam int BP_GHR_WIDTH   = 12;

    // One in-flight conditional branch: the PHT index it read and the
    // speculative history in force when it was predicted. Fields are sized
    // for the default geometry, so a controller instance must not exceed it.
    typedef struct packed {
        logic [BP_INDEX_WIDTH-1:0] index;
        logic [BP_GHR_WIDTH-1:0]   ghr;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// Program-ordered FIFO of in-flight branches with a synchronous clear that
// discards every entry and takes priority over a same-cycle push or pop.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  bp_entry_t     din_i,
    output bp_entry_t     head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    bp_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop_i)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(push_i) - CW'(pop_i);
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) r_mem[r_wr_ptr] <= din_i;
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/gshare_ctrl.sv
// gshare front-end controller: hashes PC with speculative history to index
// the PHT, tracks in-flight branches, issues PHT updates at resolution and
// repairs the speculative history on mispredict or flush.
module gshare_ctrl
    import bp_pkg::*;
#(
    parameter  int INDEX_WIDTH = BP_INDEX_WIDTH,
    parameter  int GHR_WIDTH   = BP_GHR_WIDTH,
    parameter  int DEPTH       = 8,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pred_valid_i,
    input  logic [31:0]            pred_pc_i,
    input  logic                   pred_taken_i,
    output logic                   pred_ready_o,
    output logic [INDEX_WIDTH-1:0] rd_index_o,
    input  logic                   res_valid_i,
    input  logic                   res_taken_i,
    input  logic                   res_mispredict_i,
    input  logic                   flush_i,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   br_taken_o,
    output logic [CW-1:0]          count_o,
    output logic                   empty_o
);

    // Shift a new outcome into a history value; written via a widened
    // temporary so a one-bit history needs no special case.
    function automatic logic [GHR_WIDTH-1:0] shift_in(input logic [GHR_WIDTH-1:0] ghr,
                                                      input logic             bit_in);
        logic [GHR_WIDTH:0] t;
        t = {ghr, bit_in};
        return t[GHR_WIDTH-1:0];
    endfunction

    logic [GHR_WIDTH-1:0] r_spec_ghr;
    logic [GHR_WIDTH-1:0] r_arch_ghr;
    logic [GHR_WIDTH-1:0] w_arch_nxt;
    logic [GHR_WIDTH-1:0] w_spec_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_mispred;
    logic                 w_push;
    logic                 w_clr;
    bp_entry_t            w_din;
    bp_entry_t            w_head;
    logic                 w_unused_pc;

    assign w_unused_pc = ^{pred_pc_i[31:INDEX_WIDTH+2], pred_pc_i[1:0]};

    assign rd_index_o   = pred_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(r_spec_ghr);
    // Ready ignores a same-cycle pop so ready never depends on res_valid_i.
    assign pred_ready_o = !w_full;
    assign empty_o      = w_empty;

    assign w_pop     = res_valid_i && !w_empty;
    assign w_mispred = w_pop && res_mispredict_i;
    assign w_push    = pred_valid_i && !w_full && !flush_i && !w_mispred;
    assign w_clr     = flush_i || w_mispred;

    // Entry captured on push and the repaired/advanced histories.
    always_comb begin
        w_din       = '0;
        w_din.index = BP_INDEX_WIDTH'(rd_index_o);
        w_din.ghr   = BP_GHR_WIDTH'(r_spec_ghr);

        w_arch_nxt = w_pop ? shift_in(r_arch_ghr, res_taken_i) : r_arch_ghr;

        w_spec_nxt = r_spec_ghr;
        if (w_mispred)
            w_spec_nxt = shift_in(GHR_WIDTH'(w_head.ghr), res_taken_i);
        else if (flush_i)
            w_spec_nxt = w_arch_nxt;
        else if (w_push)
            w_spec_nxt = shift_in(r_spec_ghr, pred_taken_i);
    end

    // History registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_spec_ghr <= '0;
            r_arch_ghr <= '0;
        end else begin
            r_spec_ghr <= w_spec_nxt;
            r_arch_ghr <= w_arch_nxt;
        end
    end

    // Registered PHT update port: one strobe per pop, cancelled by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            update_en_o    <= 1'b0;
            update_index_o <= '0;
            br_taken_o     <= 1'b0;
        end else begin
            update_en_o <= w_pop;
            if (w_pop) begin
                update_index_o <= INDEX_WIDTH'(w_head.index);
                br_taken_o     <= res_taken_i;
            end
        end
    end

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clr),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_gshare_ctrl.sv
// Self-checking bench for gshare_ctrl (INDEX_WIDTH=4, GHR_WIDTH=4, DEPTH=4):
// directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the predictor front end.
module tb_gshare_ctrl;

    localparam int IW = 4;
    localparam int GW = 4;
    localparam int D  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          pred_valid_i;
    logic [31:0]   pred_pc_i;
    logic          pred_taken_i;
    logic          pred_ready_o;
    logic [IW-1:0] rd_index_o;
    logic          res_valid_i;
    logic          res_taken_i;
    logic          res_mispredict_i;
    logic          flush_i;
    logic          update_en_o;
    logic [IW-1:0] update_index_o;
    logic          br_taken_o;
    logic [2:0]    count_o;
    logic          empty_o;

    always #5 clk_i = ~clk_i;

    gshare_ctrl #(
        .INDEX_WIDTH (IW),
        .GHR_WIDTH   (GW),
        .DEPTH       (D)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pred_valid_i     (pred_valid_i),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_i     (pred_taken_i),
        .pred_ready_o     (pred_ready_o),
        .rd_index_o       (rd_index_o),
        .res_valid_i      (res_valid_i),
        .res_taken_i      (res_taken_i),
        .res_mispredict_i (res_mispredict_i),
        .flush_i          (flush_i),
        .update_en_o      (update_en_o),
        .update_index_o   (update_index_o),
        .br_taken_o       (br_taken_o),
        .count_o          (count_o),
        .empty_o          (empty_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: in-flight branches in program order.
    int unsigned q_idx[$];
    int unsigned q_ghr[$];
    int unsigned m_spec, m_arch;
    int unsigned m_upd_en, m_upd_idx, m_br;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_index();
        return ((pred_pc_i >> 2) ^ m_spec) & 32'hF;
    endfunction

    task automatic model_reset();
        q_idx.delete();
        q_ghr.delete();
        m_spec = 0; m_arch = 0;
        m_upd_en = 0; m_upd_idx = 0; m_br = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_index"},  32'(rd_index_o),     exp_index());
        chk({tag, ".ready"},     32'(pred_ready_o),   32'(q_idx.size() < D));
        chk({tag, ".count"},     32'(count_o),        32'(q_idx.size()));
        chk({tag, ".empty"},     32'(empty_o),        32'(q_idx.size() == 0));
        chk({tag, ".upd_en"},    32'(update_en_o),    m_upd_en);
        chk({tag, ".upd_idx"},   32'(update_index_o), m_upd_idx);
        chk({tag, ".br_taken"},  32'(br_taken_o),     m_br);
    endtask

    // Apply the controller's rules to the model for the coming clock edge.
    task automatic model_edge();
        bit          pop, mis, push;
        int unsigned idx, hghr;
        idx  = exp_index();
        pop  = res_valid_i && (q_idx.size() != 0);
        mis  = pop && res_mispredict_i;
        push = pred_valid_i && (q_idx.size() < D) && !flush_i && !mis;
        hghr = 0;
        m_upd_en = pop;
        if (pop) begin
            m_upd_idx = q_idx.pop_front();
            hghr      = q_ghr.pop_front();
            m_br      = res_taken_i;
            m_arch    = ((m_arch << 1) | res_taken_i) & 32'hF;
        end
        if (mis) begin
            q_idx.delete(); q_ghr.delete();
            m_spec = ((hghr << 1) | res_taken_i) & 32'hF;
        end else if (flush_i) begin
            q_idx.delete(); q_ghr.delete();
            m_spec = m_arch;
        end else if (push) begin
            q_idx.push_back(idx);
            q_ghr.push_back(m_spec);
            m_spec = ((m_spec << 1) | pred_taken_i) & 32'hF;
        end
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input bit pt,
                         input bit rv, input bit rt, input bit rm, input bit fl);
        pred_valid_i = pv; pred_pc_i = pc; pred_taken_i = pt;
        res_valid_i = rv; res_taken_i = rt; res_mispredict_i = rm; flush_i = fl;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(0, pc, 0, 0, 0, 0, 0);
    endtask

    // Check current outputs, advance the model, then take one clock edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle(32'h0);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        idle(32'h0);
        #2;

        // Reset and hash
        do_reset();
        drive(1, 32'h40, 1, 0, 0, 0, 0);
        #1 chk("hash_pc40", 32'(rd_index_o), 32'h0);
        cycle("hash_a");
        drive(1, 32'h44, 0, 0, 0, 0, 0);
        #1 chk("hash_pc44", 32'(rd_index_o), 32'h0);
        cycle("hash_b");

        // Correct resolve
        do_reset();
        drive(1, 32'h0C, 1, 0, 0, 0, 0);
        cycle("res_push");
        drive(0, 32'h0, 0, 1, 1, 0, 0);
        cycle("res_pop");
        idle(32'h0);
        #1;
        chk("res_upd_en", 32'(update_en_o), 32'h1);
        chk("res_upd_idx", 32'(update_index_o), 32'h3);
        chk("res_br", 32'(br_taken_o), 32'h1);
        chk("res_count", 32'(count_o), 32'h0);
        cycle("res_after");
        chk("res_upd_pulse", 32'(update_en_o), 32'h0);

        // Mispredict repair
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0, 1, 0, 0, 0, 0);
            cycle("mis_push");
        end
        drive(1, 32'h0, 1, 1, 0, 1, 0);
        cycle("mis_resolve");
        idle(32'h40);
        #1;
        chk("mis_count", 32'(count_o), 32'h0);
        chk("mis_rd_index", 32'(rd_index_o), 32'h0);
        cycle("mis_after");

        // Full back-pressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 1, 0, 0, 0, 0);
            cycle("full_push");
        end
        drive(1, 32'h50, 0, 0, 0, 0, 0);
        #1 chk("full_ready", 32'(pred_ready_o), 32'h0);
        cycle("full_hold");
        chk("full_count", 32'(count_o), 32'h4);
        drive(1, 32'h50, 0, 1, 1, 0, 0);
        cycle("full_pop");
        drive(1, 32'h50, 0, 0, 0, 0, 0);
        #1 chk("full_ready_again", 32'(pred_ready_o), 32'h1);
        cycle("full_fifth");
        chk("full_count4", 32'(count_o), 32'h4);

        // Flush with resolve: arch history 0001 first, then 0011 after flush
        do_reset();
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        cycle("fl_push0");
        drive(0, 32'h0, 0, 1, 1, 0, 0);
        cycle("fl_res0");
        drive(1, 32'h8, 1, 0, 0, 0, 0);
        cycle("fl_push1");
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        cycle("fl_push2");
        drive(0, 32'h0, 0, 1, 1, 0, 1);
        cycle("fl_flush");
        idle(32'h0);
        #1;
        chk("fl_upd_en", 32'(update_en_o), 32'h1);
        chk("fl_count", 32'(count_o), 32'h0);
        chk("fl_spec_ghr", 32'(rd_index_o), 32'h3);
        cycle("fl_after");

        // Empty resolve is ignored
        drive(0, 32'h0, 0, 1, 1, 1, 0);
        cycle("empty_res");
        chk("empty_no_upd", 32'(update_en_o), 32'h0);

        // Reset mid-operation cancels a pending update
        drive(1, 32'h4, 1, 0, 0, 0, 0);
        cycle("mid_push");
        drive(0, 32'h0, 0, 1, 0, 0, 0);
        cycle("mid_pop");
        idle(32'h0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_upd_en", 32'(update_en_o), 32'h0);
        chk("mid_rst_count", 32'(count_o), 32'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
                  $urandom_range(0, 2) == 0, 1'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            cycle("rand");
        end
        idle(32'h0);
        #1 check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
